// File: rtl/stream_serializer_pkg.sv
// Shared types for the stream serializer: the two-state shift FSM encoding.
package stream_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

endpackage

// File: rtl/stream_serializer_if.sv
// Word-in / chunk-out handshake bundle; master is the source/strobe side, slave is the serializer.
interface stream_serializer_if #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 2
);

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_en;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;

    modport master (
        output in_valid, in_data, in_last, out_en,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_en,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/stream_serializer.sv
// Width reducer: IN_WIDTH-bit words out as OUT_WIDTH-bit chunks, LSB first, one per out_en.
// A one-word hold register behind the shift register lets consecutive words stream gap-free.
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 2
) (
    input logic               clk,
    input logic               reset,
    stream_serializer_if.slave bus
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] sreg_q, sreg_d;
    logic                slast_q, slast_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                hold_last_q, hold_last_d;
    logic                hold_valid_q, hold_valid_d;

    logic accept;
    logic advance;
    logic word_done;

    assign accept    = bus.in_valid && !hold_valid_q;
    assign advance   = bus.out_en && (state_q == StShift);
    assign word_done = advance && (cnt_q == CNT_LAST);

    assign bus.in_ready  = !hold_valid_q;
    assign bus.out_valid = (state_q == StShift);
    assign bus.out_data  = sreg_q[OUT_WIDTH-1:0];
    assign bus.out_last  = (state_q == StShift) && slast_q && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        slast_d      = slast_q;
        cnt_d        = cnt_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = bus.in_data;
                    slast_d = bus.in_last;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (word_done) begin
                    // Held word takes priority; accept cannot coincide since in_ready is low.
                    if (hold_valid_q) begin
                        sreg_d       = hold_data_q;
                        slast_d      = hold_last_q;
                        hold_valid_d = 1'b0;
                        cnt_d        = '0;
                    end else if (accept) begin
                        sreg_d  = bus.in_data;
                        slast_d = bus.in_last;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end else begin
                    if (advance) begin
                        sreg_d = sreg_q >> OUT_WIDTH;
                        cnt_d  = cnt_q + 1'b1;
                    end
                    if (accept) begin
                        hold_data_d  = bus.in_data;
                        hold_last_d  = bus.in_last;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sreg_q       <= '0;
            slast_q      <= 1'b0;
            cnt_q        <= '0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            slast_q      <= slast_d;
            cnt_q        <= cnt_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule
